// File: rtl/instr_fetch_if.sv
// Fetch-stage bus bundle: instruction-memory read port, redirect input and
// the decode-facing valid/ready port with occupancy.
interface instr_fetch_if #(
    parameter int unsigned INSTR_W = 17,
    parameter int unsigned ADDR_W  = 5,
    parameter int unsigned DEPTH   = 4
);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic               imem_req;
    logic [ADDR_W-1:0]  imem_addr;
    logic [INSTR_W-1:0] imem_rdata;
    logic               redirect_valid;
    logic [ADDR_W-1:0]  redirect_pc;
    logic               out_valid;
    logic               out_ready;
    logic [INSTR_W-1:0] out_instr;
    logic [ADDR_W-1:0]  out_pc;
    logic [CNT_W-1:0]   count;

    modport master (
        output imem_req, imem_addr, out_valid, out_instr, out_pc, count,
        input  imem_rdata, redirect_valid, redirect_pc, out_ready
    );

    modport slave (
        input  imem_req, imem_addr, out_valid, out_instr, out_pc, count,
        output imem_rdata, redirect_valid, redirect_pc, out_ready
    );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch: PC sequencing, one-cycle-latency imem reads and a
// credit-checked prefetch FIFO presented to decode over valid/ready.
module instr_fetch #(
    parameter int unsigned INSTR_W = 17,
    parameter int unsigned ADDR_W  = 5,
    parameter int unsigned DEPTH   = 4
) (
    input logic           clk,
    input logic           rst,
    instr_fetch_if.master bus
);
    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned USED_W = CNT_W + 1;

    logic [ADDR_W-1:0]  fetch_pc_q;
    logic               inflight_q;
    logic [ADDR_W-1:0]  inflight_pc_q;
    logic [PTR_W-1:0]   rd_ptr_q, wr_ptr_q;
    logic [CNT_W-1:0]   count_q;
    logic [ADDR_W-1:0]  pc_mem_q    [DEPTH];
    logic [INSTR_W-1:0] instr_mem_q [DEPTH];

    logic              issue, push, pop, out_valid;
    logic [USED_W-1:0] used;

    always_comb begin
        // Credit counts the in-flight read so a response always has a slot.
        used      = USED_W'(count_q) + USED_W'(inflight_q);
        issue     = !rst && !bus.redirect_valid && (used < USED_W'(DEPTH));
        push      = inflight_q && !bus.redirect_valid;
        out_valid = !rst && (count_q != '0);
        pop       = out_valid && bus.out_ready;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q    <= '0;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
        end else if (bus.redirect_valid) begin
            fetch_pc_q <= bus.redirect_pc;
            inflight_q <= 1'b0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            inflight_q <= issue;
            if (issue) begin
                inflight_pc_q <= fetch_pc_q;
                fetch_pc_q    <= fetch_pc_q + ADDR_W'(1);
            end
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            if (push && !pop)      count_q <= count_q + CNT_W'(1);
            else if (!push && pop) count_q <= count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem_q[wr_ptr_q]    <= inflight_pc_q;
            instr_mem_q[wr_ptr_q] <= bus.imem_rdata;
        end
    end

    always_comb begin
        bus.imem_req  = issue;
        bus.imem_addr = fetch_pc_q;
        bus.out_valid = out_valid;
        bus.out_instr = instr_mem_q[rd_ptr_q];
        bus.out_pc    = pc_mem_q[rd_ptr_q];
        bus.count     = rst ? '0 : count_q;
    end
endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: streaming, backpressure, wrap, redirects
// and mid-stream reset against a memory holding 100+addr.
module tb_instr_fetch;
    localparam int unsigned INSTR_W = 17;
    localparam int unsigned ADDR_W  = 5;
    localparam int unsigned DEPTH   = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fails  = 0;

    instr_fetch_if #(.INSTR_W(INSTR_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) bus ();

    instr_fetch #(.INSTR_W(INSTR_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    logic [INSTR_W-1:0] mem [32];
    always @(posedge clk) begin
        if (bus.imem_req) bus.imem_rdata <= mem[bus.imem_addr];
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Holds rst for one cycle; returns positioned in cycle 0.
    task automatic do_reset(input logic ready);
        rst = 1'b1;
        bus.out_ready = ready;
        bus.redirect_valid = 1'b0;
        #1;
        check_eq("rst_req", 32'(bus.imem_req), 0);
        check_eq("rst_valid", 32'(bus.out_valid), 0);
        check_eq("rst_count", 32'(bus.count), 0);
        next_cycle();
        rst = 1'b0;
        #1;
    endtask

    task automatic check_head(input string tag, input int pc);
        check_eq({tag, "_valid"}, 32'(bus.out_valid), 1);
        check_eq({tag, "_pc"}, 32'(bus.out_pc), 32'(pc));
        check_eq({tag, "_instr"}, 32'(bus.out_instr), 32'(100 + pc));
    endtask

    initial begin
        int reqs;
        for (int i = 0; i < 32; i++) mem[i] = INSTR_W'(100 + i);
        bus.out_ready = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = '0;
        bus.imem_rdata = '0;
        next_cycle();

        // Streaming from reset, 40+ cycles, covering pc wrap 31 -> 0.
        do_reset(1'b1);
        check_eq("c0_req", 32'(bus.imem_req), 1);
        check_eq("c0_addr", 32'(bus.imem_addr), 0);
        check_eq("c0_valid", 32'(bus.out_valid), 0);
        next_cycle(); #1;
        check_eq("c1_valid", 32'(bus.out_valid), 0);
        check_eq("c1_addr", 32'(bus.imem_addr), 1);
        for (int k = 0; k < 40; k++) begin
            next_cycle(); #1;
            check_head("stream", k % 32);
            check_eq("stream_count", 32'(bus.count), 1);
        end

        // Backpressure from reset: exactly DEPTH requests, then drain in order.
        do_reset(1'b0);
        reqs = 0;
        for (int k = 0; k < 10; k++) begin
            if (k > 0) begin next_cycle(); #1; end
            if (bus.imem_req) reqs++;
        end
        check_eq("bp_reqs", 32'(reqs), 4);
        check_eq("bp_count", 32'(bus.count), 4);
        check_head("bp_hold", 0);
        next_cycle();
        bus.out_ready = 1'b1;
        #1;
        for (int k = 0; k < 10; k++) begin
            if (k > 0) begin next_cycle(); #1; end
            check_head("bp_drain", k);
        end

        // Redirect with pcs 4,5,6 buffered and pc 7 in flight, out_ready low.
        do_reset(1'b1);
        for (int k = 0; k < 6; k++) next_cycle();
        bus.out_ready = 1'b0;
        #1;
        check_head("rd_pre", 4);
        next_cycle(); next_cycle();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 5'd20;
        #1;
        check_eq("rd_R_count", 32'(bus.count), 3);
        check_eq("rd_R_req", 32'(bus.imem_req), 0);
        next_cycle();
        bus.redirect_valid = 1'b0;
        bus.out_ready = 1'b1;
        #1;
        check_eq("rd_R1_count", 32'(bus.count), 0);
        check_eq("rd_R1_valid", 32'(bus.out_valid), 0);
        check_eq("rd_R1_req", 32'(bus.imem_req), 1);
        check_eq("rd_R1_addr", 32'(bus.imem_addr), 20);
        next_cycle(); #1;
        check_eq("rd_R2_count", 32'(bus.count), 0);
        check_eq("rd_R2_valid", 32'(bus.out_valid), 0);
        next_cycle(); #1;
        check_head("rd_R3", 20);
        next_cycle(); #1;
        check_head("rd_R4", 21);

        // Redirect to 9 while the pc 3 handshake completes.
        do_reset(1'b1);
        for (int k = 0; k < 5; k++) next_cycle();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 5'd9;
        #1;
        check_head("hs_R", 3);
        next_cycle();
        bus.redirect_valid = 1'b0;
        #1;
        check_eq("hs_R1_valid", 32'(bus.out_valid), 0);
        next_cycle(); #1;
        check_eq("hs_R2_valid", 32'(bus.out_valid), 0);
        next_cycle(); #1;
        check_head("hs_R3", 9);
        next_cycle(); #1;
        check_head("hs_R4", 10);

        // Mid-stream reset with count 3, then a clean restart.
        do_reset(1'b1);
        for (int k = 0; k < 6; k++) next_cycle();
        bus.out_ready = 1'b0;
        next_cycle(); next_cycle();
        #1;
        check_eq("mr_pre_count", 32'(bus.count), 3);
        do_reset(1'b1);
        check_eq("mr_c0_count", 32'(bus.count), 0);
        check_eq("mr_c0_valid", 32'(bus.out_valid), 0);
        check_eq("mr_c0_addr", 32'(bus.imem_addr), 0);
        next_cycle(); #1;
        check_eq("mr_c1_valid", 32'(bus.out_valid), 0);
        next_cycle(); #1;
        check_head("mr_c2", 0);
        next_cycle(); #1;
        check_head("mr_c3", 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
